packet_unpack: RTL and testbench



---
 rtl/packet_unpack.sv | 200 ++++++++++++++++++++
 tb/tb_packet_unpack.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/packet_unpack.sv
// ---------------------------------------------------------------------------
// packet_unpack
//
// Receive-side counterpart of the packet filler. Accepts one 73-bit packet
// {valid, check[7:0], data[63:0]} per handshake, checks the parity of every
// data byte against its check bit, and replays the 8 data bytes one per
// handshake on a byte stream, byte 0 (data[7:0]) first. A saturating counter
// tracks how many valid packets carried at least one parity mismatch.
//
// Ports
//   clock          in   1   rising-edge clock
//   resetN         in   1   asynchronous active-low reset
//   pkt_in         in  73   packet {valid, check[7:0], data[63:0]}
//   pkt_in_valid   in   1   pkt_in is offered
//   pkt_in_ready   out  1   block can accept a packet (FSM in IDLE)
//   byte_out       out  8   current data byte (0 when idle)
//   byte_idx       out  3   index of byte_out within the packet
//   byte_last      out  1   byte_idx == 7 while a byte is offered
//   byte_err       out  1   byte_out parity disagrees with its check bit
//   byte_out_valid out  1   byte_out is offered
//   byte_out_ready in   1   consumer accepts byte_out
//   bad_pkt_cnt    out  8   saturating count of packets with parity errors
//   busy           out  1   FSM in SEND
//
// Build option
//   PACKET_UNPACK_DROP_BAD_EN  when defined, a valid packet with any parity
//                              mismatch is dropped whole (still counted) and
//                              byte_err is tied low. When undefined, bad
//                              packets are emitted with byte_err flagging the
//                              offending bytes.
// ---------------------------------------------------------------------------
module packet_unpack (
    input  logic        clock,
    input  logic        resetN,
    input  logic [72:0] pkt_in,
    input  logic        pkt_in_valid,
    output logic        pkt_in_ready,
    output logic [7:0]  byte_out,
    output logic [2:0]  byte_idx,
    output logic        byte_last,
    output logic        byte_err,
    output logic        byte_out_valid,
    input  logic        byte_out_ready,
    output logic [7:0]  bad_pkt_cnt,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [63:0] data_q;
    logic [2:0]  idx_q;
    logic [7:0]  cnt_q;

    logic        pkt_flag;
    logic [7:0]  pkt_check;
    logic [63:0] pkt_data;
    logic [7:0]  mismatch_in;
    logic        any_mismatch;

    logic        accept;
    logic        start_send;
    logic        count_bad;
    logic        handshake;
    logic        last_handshake;

    assign pkt_flag  = pkt_in[72];
    assign pkt_check = pkt_in[71:64];
    assign pkt_data  = pkt_in[63:0];

    // Per-byte parity compared against the matching check bit.
    always_comb begin
        mismatch_in = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            mismatch_in[i] = (^pkt_data[8*i +: 8]) ^ pkt_check[i];
        end
    end

    assign any_mismatch = |mismatch_in;

    // Handshake terms are built from the state register directly rather
    // than from the ready/valid outputs so the FSM block never reads back
    // its own combinational outputs.
    assign accept         = pkt_in_valid && (state == IDLE);
    assign handshake      = byte_out_ready && (state == SEND);
    assign last_handshake = handshake && (idx_q == 3'd7);
    assign count_bad      = accept && pkt_flag && any_mismatch;

`ifdef PACKET_UNPACK_DROP_BAD_EN
    assign start_send = accept && pkt_flag && !any_mismatch;
`else
    assign start_send = accept && pkt_flag;
`endif

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        pkt_in_ready   = 1'b0;
        byte_out_valid = 1'b0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                pkt_in_ready = 1'b1;
                if (start_send) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                byte_out_valid = 1'b1;
                busy           = 1'b1;
                if (last_handshake) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Packet holding registers and byte index
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            data_q <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            data_q <= pkt_data;
            idx_q  <= '0;
        end else if (handshake) begin
            // Wraps 7 -> 0 on the final handshake, leaving idx ready for
            // the next packet.
            idx_q <= idx_q + 3'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Bad-packet counter, saturating at 255
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else if (count_bad && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign bad_pkt_cnt = cnt_q;

    // -----------------------------------------------------------------------
    // Byte stream outputs; forced to zero outside SEND
    // -----------------------------------------------------------------------
    always_comb begin
        byte_out  = '0;
        byte_idx  = '0;
        byte_last = 1'b0;
        if (state == SEND) begin
            byte_out  = data_q[{idx_q, 3'b000} +: 8];
            byte_idx  = idx_q;
            byte_last = (idx_q == 3'd7);
        end
    end

`ifdef PACKET_UNPACK_DROP_BAD_EN
    // Bad packets never reach SEND, so no per-byte flag is kept.
    assign byte_err = 1'b0;
`else
    logic [7:0] mismatch_q;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mismatch_q <= '0;
        end else if (accept) begin
            mismatch_q <= mismatch_in;
        end
    end

    assign byte_err = (state == SEND) && mismatch_q[idx_q];
`endif

endmodule

// File: tb/tb_packet_unpack.sv
// ---------------------------------------------------------------------------
// tb_packet_unpack
//
// Self-checking bench for packet_unpack. A table of per-cycle records
// {inputs, expected outputs} covers the streaming, back-pressure, bad-parity
// and invalid-packet cases; hand-written sequences cover reset mid-packet
// and bad-packet counter saturation.
// ---------------------------------------------------------------------------
module tb_packet_unpack;

    logic        clock = 1'b0;
    logic        resetN;
    logic [72:0] pkt_in;
    logic        pkt_in_valid;
    logic        pkt_in_ready;
    logic [7:0]  byte_out;
    logic [2:0]  byte_idx;
    logic        byte_last;
    logic        byte_err;
    logic        byte_out_valid;
    logic        byte_out_ready;
    logic [7:0]  bad_pkt_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    packet_unpack dut (
        .clock          (clock),
        .resetN         (resetN),
        .pkt_in         (pkt_in),
        .pkt_in_valid   (pkt_in_valid),
        .pkt_in_ready   (pkt_in_ready),
        .byte_out       (byte_out),
        .byte_idx       (byte_idx),
        .byte_last      (byte_last),
        .byte_err       (byte_err),
        .byte_out_valid (byte_out_valid),
        .byte_out_ready (byte_out_ready),
        .bad_pkt_cnt    (bad_pkt_cnt),
        .busy           (busy)
    );

    // Byte parities of DATA: 04->1, 02->1, 00->0, 01->1, rest 0.
    localparam logic [63:0] DATA = 64'h0000_0000_0100_0204;
    localparam logic [72:0] GOOD = {1'b1, 8'b00001011, DATA};
    // check[0] cleared: byte 0 (value 4) is the mismatching byte.
    localparam logic [72:0] BADP = {1'b1, 8'b00001010, DATA};
    localparam logic [72:0] INV  = {1'b0, 8'b00001011, DATA};

    logic [7:0] exp_bytes [8];

    typedef struct {
        logic [72:0] pkt;
        logic        pv;
        logic        ordy;
        logic        prdy;
        logic        bov;
        logic [7:0]  b;
        logic [2:0]  idx;
        logic        last;
        logic        err;
        logic [7:0]  cnt;
        logic        bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [72:0] p, input logic pv, input logic ordy,
                                input logic prdy, input logic bov, input logic [7:0] b,
                                input logic [2:0] idx, input logic last, input logic err,
                                input logic [7:0] cnt);
        vec_t v;
        v.pkt = p;  v.pv = pv;   v.ordy = ordy;
        v.prdy = prdy; v.bov = bov; v.b = b; v.idx = idx;
        v.last = last; v.err = err; v.cnt = cnt; v.bsy = bov;
        vecs.push_back(v);
    endfunction

    function automatic void add_idle(input logic [72:0] p, input logic pv, input logic [7:0] cnt);
        add(p, pv, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, cnt);
    endfunction

    function automatic void add_byte(input logic [72:0] p, input logic pv, input logic ordy,
                                     input int k, input logic err, input logic [7:0] cnt);
        add(p, pv, ordy, 1'b0, 1'b1, exp_bytes[k], 3'(k), (k == 7), err, cnt);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input vec_t v);
        chk({tag, ".pkt_in_ready"},   8'(pkt_in_ready),   8'(v.prdy));
        chk({tag, ".byte_out_valid"}, 8'(byte_out_valid), 8'(v.bov));
        chk({tag, ".byte_out"},       byte_out,           v.b);
        chk({tag, ".byte_idx"},       8'(byte_idx),       8'(v.idx));
        chk({tag, ".byte_last"},      8'(byte_last),      8'(v.last));
        chk({tag, ".byte_err"},       8'(byte_err),       8'(v.err));
        chk({tag, ".bad_pkt_cnt"},    bad_pkt_cnt,        v.cnt);
        chk({tag, ".busy"},           8'(busy),           8'(v.bsy));
    endtask

    task automatic chk_reset_values(input string tag);
        vec_t r;
        r.pkt = '0; r.pv = 1'b0; r.ordy = 1'b0;
        r.prdy = 1'b1; r.bov = 1'b0; r.b = 8'h00; r.idx = 3'd0;
        r.last = 1'b0; r.err = 1'b0; r.cnt = 8'd0; r.bsy = 1'b0;
        chk_vec(tag, r);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!pkt_in_ready && n < 32) begin
            step();
            n++;
        end
        if (!pkt_in_ready) begin
            total++;
            bad++;
            $display("FAIL %s: pkt_in_ready got 0 want 1 within 32 cycles", tag);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_bytes = '{8'h04, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};

        // Streaming with ready high.
        add_idle(GOOD, 1'b1, 8'd0);
        for (int k = 0; k < 8; k++) add_byte('0, 1'b0, 1'b1, k, 1'b0, 8'd0);
        // Back-pressure: ready toggles 0/1 while upstream keeps offering.
        add_idle(GOOD, 1'b1, 8'd0);
        for (int k = 0; k < 8; k++) begin
            add_byte(GOOD, 1'b1, 1'b0, k, 1'b0, 8'd0);
            add_byte(GOOD, 1'b1, 1'b1, k, 1'b0, 8'd0);
        end
        // Bad parity on byte 0.
        add_idle(BADP, 1'b1, 8'd0);
`ifndef PACKET_UNPACK_DROP_BAD_EN
        for (int k = 0; k < 8; k++) add_byte('0, 1'b0, 1'b1, k, (k == 0), 8'd1);
`endif
        // Invalid packet is swallowed, then a good one streams.
        add_idle(INV, 1'b1, 8'd1);
        add_idle(GOOD, 1'b1, 8'd1);
        for (int k = 0; k < 8; k++) add_byte('0, 1'b0, 1'b1, k, 1'b0, 8'd1);
        add_idle('0, 1'b0, 8'd1);

        resetN         = 1'b0;
        pkt_in         = '0;
        pkt_in_valid   = 1'b0;
        byte_out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_values("reset");
        resetN = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            pkt_in         = vecs[i].pkt;
            pkt_in_valid   = vecs[i].pv;
            byte_out_ready = vecs[i].ordy;
            #1;
            chk_vec($sformatf("vec%0d", i), vecs[i]);
            @(posedge clock);
            #1;
        end

        // Reset after byte 3 is accepted.
        pkt_in         = GOOD;
        pkt_in_valid   = 1'b1;
        byte_out_ready = 1'b1;
        step();
        pkt_in_valid = 1'b0;
        repeat (4) step();
        chk("midrst.idx_before", 8'(byte_idx), 8'd4);
        chk("midrst.busy_before", 8'(busy), 8'd1);
        #2;
        resetN = 1'b0;
        #1;
        chk_reset_values("midrst");
        @(posedge clock);
        #3;
        resetN = 1'b1;
        step();
        pkt_in_valid = 1'b1;
        step();
        pkt_in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("postrst.byte%0d", k), byte_out, exp_bytes[k]);
            chk($sformatf("postrst.idx%0d", k), 8'(byte_idx), 8'(k));
            chk($sformatf("postrst.valid%0d", k), 8'(byte_out_valid), 8'd1);
            step();
        end
        wait_ready("postrst.done");

        // Counter saturation over 256 bad packets.
        byte_out_ready = 1'b1;
        pkt_in         = BADP;
        for (int p = 1; p <= 256; p++) begin
            pkt_in_valid = 1'b1;
            step();
            pkt_in_valid = 1'b0;
            wait_ready($sformatf("sat.pkt%0d", p));
            if (p == 1)   chk("sat.cnt1",   bad_pkt_cnt, 8'd1);
            if (p == 254) chk("sat.cnt254", bad_pkt_cnt, 8'd254);
            if (p == 255) chk("sat.cnt255", bad_pkt_cnt, 8'd255);
            if (p == 256) chk("sat.cnt256", bad_pkt_cnt, 8'd255);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
